// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one external memory bus between the instruction
// fetch port and the data port. Data has fixed priority, one transaction is
// outstanding at a time, and a BUSY timeout completes the request with an
// error. A fetch can be squashed by abort; it then finishes on the bus
// silently, so the front end only ever waits on i_ack/i_err.
module mem_bus_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic        i_err,
  output logic [31:0] i_rdata,
  input  logic        abort,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  // Last BUSY count value before the transaction is declared timed out.
  localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT - 1);

  logic [1:0]  state;
  logic        owner;
  logic        killed;
  logic        resp_err;
  logic [15:0] count;
  logic [31:0] resp_data;
  logic [31:0] i_hold;
  logic [31:0] d_hold;
  logic        resp_valid;
  logic        i_visible;
  logic        d_visible;

  // Arbitration, bus request registers, timeout counter and squash tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= OWNER_I;
      killed    <= 1'b0;
      resp_err  <= 1'b0;
      count     <= '0;
      resp_data <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_be    <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_req) begin
            owner     <= OWNER_D;
            bus_we    <= d_we;
            bus_be    <= d_be;
            bus_addr  <= d_addr;
            bus_wdata <= d_wdata;
            bus_req   <= 1'b1;
            count     <= '0;
            killed    <= 1'b0;
            state     <= BUSY;
          end else if (i_req && !abort) begin
            owner     <= OWNER_I;
            bus_we    <= 1'b0;
            bus_be    <= 4'hF;
            bus_addr  <= i_addr;
            bus_wdata <= '0;
            bus_req   <= 1'b1;
            count     <= '0;
            killed    <= 1'b0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (abort && owner == OWNER_I) begin
            killed <= 1'b1;
          end
          if (bus_ack) begin
            bus_req   <= 1'b0;
            resp_data <= bus_rdata;
            resp_err  <= 1'b0;
            state     <= RESP;
          end else if (count == LAST_COUNT) begin
            bus_req   <= 1'b0;
            resp_data <= '0;
            resp_err  <= 1'b1;
            state     <= RESP;
          end else begin
            count <= count + 16'd1;
          end
        end
        RESP: begin
          killed <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // An abort during the response cycle itself must still hide the fetch
  // completion, so the squash term includes the live abort input.
  assign resp_valid = (state == RESP);
  assign i_visible  = resp_valid && (owner == OWNER_I) && !killed && !abort;
  assign d_visible  = resp_valid && (owner == OWNER_D);

  // Read data holding registers, refreshed only by a visible completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_hold <= '0;
      d_hold <= '0;
    end else begin
      if (i_visible) begin
        i_hold <= resp_data;
      end
      if (d_visible) begin
        d_hold <= resp_data;
      end
    end
  end

  assign i_ack   = i_visible && !resp_err;
  assign i_err   = i_visible && resp_err;
  assign i_rdata = i_visible ? resp_data : i_hold;
  assign d_ack   = d_visible && !resp_err;
  assign d_err   = d_visible && resp_err;
  assign d_rdata = d_visible ? resp_data : d_hold;
  assign busy    = (state != IDLE);

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single external memory bus between the instruction-fetch port (IF) and the data port (MEM stage).
- Serialises requests one transaction at a time, with fixed priority to data.
- Registers the bus request and handshakes it to completion, with a timeout that reports a bus error.
- Supports squashing an in-flight fetch on exception or redirect, so the pipeline stalls on its acks instead of talking to memory directly.

Parameters:
- TIMEOUT, 255: max BUSY cycles waiting for bus_ack before error completion. Range 1..65535; the counter is 16 bits.

Ports:
- clk  in  1  clock
- rst  in  1  async active-high reset
- i_req  in  1  fetch request; held until i_ack/i_err or until squashed
- i_addr  in  32  fetch address, word-aligned
- i_ack  out  1  one-cycle fetch completion
- i_err  out  1  one-cycle fetch error (timeout), exclusive with i_ack
- i_rdata  out  32  fetch data, valid with i_ack
- abort  in  1  squash the fetch port (exn/branch redirect)
- d_req  in  1  data request; held until d_ack/d_err
- d_we  in  1  1 = write
- d_be  in  4  byte enables
- d_addr  in  32  data address
- d_wdata  in  32  write data
- d_ack  out  1  one-cycle data completion
- d_err  out  1  one-cycle data error, exclusive with d_ack
- d_rdata  out  32  read data, valid with d_ack
- bus_req  out  1  bus request, registered
- bus_we  out  1  registered
- bus_be  out  4  registered; 4'hF for fetches
- bus_addr  out  32  registered
- bus_wdata  out  32  registered; 0 for fetches
- bus_ack  in  1  transaction done; bus_rdata valid this cycle
- bus_rdata  in  32  read data
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, BUSY, RESP. A register `owner` (I/D) and a flag `killed` are held alongside the state.
- Reset (async):
  - State goes to IDLE; killed = 0; counter = 0.
  - All outputs go to 0, including bus_req, which drops immediately even mid-transaction.
  - No ack or err is emitted for a transaction cut off by reset.
- IDLE, arbitration at the clock edge:
  - d_req: owner = D. Latch d_we, d_be, d_addr, d_wdata into the bus_* registers; bus_req <= 1; go to BUSY.
  - else i_req && !abort: owner = I. Latch bus_we = 0, bus_be = 4'hF, bus_addr = i_addr, bus_wdata = 0; bus_req <= 1; go to BUSY.
  - else stay in IDLE.
  - Data wins a simultaneous request; fetch waits.
- Timing: a request sampled at edge N gives bus_req high from cycle N+1.
- BUSY:
  - bus_* outputs stay stable while bus_req is high.
  - bus_ack sampled high: bus_req <= 0; capture bus_rdata into {i,d}_rdata; go to RESP with the ok flag set.
  - else if counter == TIMEOUT-1: bus_req <= 0; rdata <= 0; go to RESP with the err flag set.
  - else counter++ (counter clears at grant).
- RESP, lasts exactly one cycle:
  - Assert exactly one of ack or err for the owner, unless owner = I and killed.
  - No arbitration this cycle. The requester drops or changes its req at the edge ending RESP; IDLE samples it on the following edge.
  - Go to IDLE; killed <= 0.
- Squash:
  - abort high in any BUSY or RESP cycle while owner = I sets killed (in RESP it suppresses the output combinationally).
  - A killed fetch still completes on the bus, but i_ack and i_err stay 0 and i_rdata is unchanged.
  - abort has no effect on data transactions.
  - In IDLE, abort only blocks granting i_req.
- bus_ack outside BUSY (e.g. a late ack after timeout) is ignored.
- Ack latency: a bus with zero wait states completes in 3 cycles per transaction. bus_req rises at N+1, bus_ack at N+1, ack at N+2, and the next grant at edge N+3.
- {i,d}_rdata hold their last value except when updated on a completion.

Test Plan:
- Fetch, bus acks on its first req cycle with 0xDEADBEEF: i_req with i_addr=0x100 sampled at edge 0. Required: bus_req=1, bus_addr=0x100, bus_be=F, bus_we=0 at cycle 1; i_ack=1 and i_rdata=0xDEADBEEF at cycle 2; bus_req=0 at cycle 2.
- d_req write (addr 0x2000, be=4'b0011, wdata 0x1234) and i_req in the same cycle: data granted first; d_ack pulses; fetch is bus_req'd at cycle 4; i_ack at cycle 5; d_rdata unaffected by the fetch.
- Fetch granted, bus_ack delayed 3 cycles, abort pulsed in the 2nd BUSY cycle: bus transaction completes; i_ack and i_err never assert; next i_req is granted normally.
- TIMEOUT=4, bus_ack never asserted on a data read: bus_req high for exactly 4 cycles; d_err=1 with d_rdata=0 for one cycle; d_ack stays 0; a bus_ack injected afterwards is ignored.
- rst asserted mid-BUSY without a clock edge: bus_req, busy and all acks go to 0 immediately; after release the block is in IDLE and grants a fresh i_req.
- Back-to-back data reads with bus_ack on every first req cycle: d_ack every 3rd cycle; bus_addr stable during each bus_req high window.
